// File: rtl/usb_tx_encoder.sv
// USB transmit encoder: turns a byte stream into D+/D- line levels.
// The packet is framed as SYNC, then the data bytes (LSB first, NRZI coded and
// bit stuffed), then EOP. A single holding register decouples the byte source
// from the bit-serial shift register.
module usb_tx_encoder #(
   parameter int unsigned CLKS_PER_BIT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       dplus_out,
   output logic       dminus_out,
   output logic       tx_busy,
   output logic       tx_error
);

   localparam int unsigned     CntW     = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntMax   = CntW'(CLKS_PER_BIT - 1);
   localparam logic [1:0]      LineJ    = 2'b10;
   localparam logic [1:0]      LineSe0  = 2'b00;
   localparam logic [7:0]      SyncByte = 8'h80;

   typedef enum logic [2:0] {StIdle, StSync, StData, StEopSe0, StEopJ} state_e;

   state_e          st_q, st_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0]      idx_q, idx_d;            // next bit of shift_q to send; 8 = byte exhausted
   logic [7:0]      shift_q, shift_d;
   logic            shift_last_q, shift_last_d;
   logic [7:0]      hold_q, hold_d;
   logic            hold_full_q, hold_full_d;
   logic            last_acc_q, last_acc_d;  // tx_last already taken for this packet
   logic [2:0]      ones_q, ones_d;
   logic [1:0]      line_q, line_d;          // {D+, D-}
   logic            eop_bit_q, eop_bit_d;
   logic            err_q, err_d;

   logic            accept, wrap, send, tx_bit, eop_start, next_last;
   logic [7:0]      next_byte;

   assign tx_ready   = !hold_full_q && !last_acc_q &&
                       ((st_q == StIdle) || (st_q == StSync) || (st_q == StData));
   assign tx_busy    = (st_q != StIdle);
   assign tx_error   = err_q;
   assign dplus_out  = line_q[1];
   assign dminus_out = line_q[0];

   // Next state: byte intake, bit-time sequencing, stuffing, NRZI and EOP framing
   always_comb begin
      st_d         = st_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      shift_d      = shift_q;
      shift_last_d = shift_last_q;
      hold_d       = hold_q;
      hold_full_d  = hold_full_q;
      last_acc_d   = last_acc_q;
      ones_d       = ones_q;
      line_d       = line_q;
      eop_bit_d    = eop_bit_q;
      err_d        = 1'b0;
      send         = 1'b0;
      tx_bit       = 1'b1;
      eop_start    = 1'b0;

      wrap      = (cnt_q == CntMax);
      accept    = tx_valid && tx_ready;
      // A byte offered on the very boundary cycle is used directly
      next_byte = hold_full_q ? hold_q : tx_data;
      next_last = hold_full_q ? last_acc_q : tx_last;

      if (accept) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
         last_acc_d  = last_acc_q | tx_last;
      end

      unique case (st_q)
         StIdle: begin
            cnt_d = '0;
            if (accept) begin
               // First SYNC bit goes out on the next cycle
               st_d         = StSync;
               shift_d      = SyncByte;
               shift_last_d = 1'b0;
               idx_d        = 4'd1;
               ones_d       = '0;
               tx_bit       = SyncByte[0];
               send         = 1'b1;
            end
         end
         StSync, StData: begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (wrap) begin
               if (ones_q == 3'd6) begin
                  tx_bit = 1'b0;  // stuffed bit, no data consumed
                  send   = 1'b1;
               end else if (idx_q != 4'd8) begin
                  tx_bit = shift_q[idx_q[2:0]];
                  send   = 1'b1;
                  idx_d  = idx_q + 4'd1;
               end else if (shift_last_q) begin
                  eop_start = 1'b1;
               end else if (hold_full_q || accept) begin
                  st_d         = StData;
                  shift_d      = next_byte;
                  shift_last_d = next_last;
                  hold_full_d  = 1'b0;
                  idx_d        = 4'd1;
                  tx_bit       = next_byte[0];
                  send         = 1'b1;
               end else begin
                  err_d     = 1'b1;  // underrun
                  eop_start = 1'b1;
               end
            end
         end
         StEopSe0: begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (wrap) begin
               eop_bit_d = 1'b1;
               if (eop_bit_q) begin
                  st_d      = StEopJ;
                  line_d    = LineJ;
                  eop_bit_d = 1'b0;
               end
            end
         end
         StEopJ: begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (wrap) begin
               st_d       = StIdle;
               last_acc_d = 1'b0;
            end
         end
         default: st_d = StIdle;
      endcase

      // NRZI: a 0 toggles J<->K, a 1 holds the line
      if (send) begin
         line_d = tx_bit ? line_q : ~line_q;
         ones_d = tx_bit ? ones_q + 3'd1 : 3'd0;
      end
      if (eop_start) begin
         st_d      = StEopSe0;
         line_d    = LineSe0;
         eop_bit_d = 1'b0;
         ones_d    = '0;
      end
   end

   // State registers with synchronous reset to an idle J line
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q         <= StIdle;
         cnt_q        <= '0;
         idx_q        <= '0;
         shift_q      <= '0;
         shift_last_q <= 1'b0;
         hold_q       <= '0;
         hold_full_q  <= 1'b0;
         last_acc_q   <= 1'b0;
         ones_q       <= '0;
         line_q       <= LineJ;
         eop_bit_q    <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         st_q         <= st_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
         shift_last_q <= shift_last_d;
         hold_q       <= hold_d;
         hold_full_q  <= hold_full_d;
         last_acc_q   <= last_acc_d;
         ones_q       <= ones_d;
         line_q       <= line_d;
         eop_bit_q    <= eop_bit_d;
         err_q        <= err_d;
      end
   end

endmodule
